// File: rtl/tap_delay_line_if.sv
// Control/data bundle for tap_delay_line: the driver side owns the
// shift controls, data and tap select; the delay line returns the tapped word.
interface tap_delay_line_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
);
  logic             en;
  logic             flush;
  logic             rotate;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             full;
  logic             sel_err;

  modport master (
    output en, flush, rotate, d, d_valid, sel,
    input  q, q_valid, full, sel_err
  );

  modport slave (
    input  en, flush, rotate, d, d_valid, sel,
    output q, q_valid, full, sel_err
  );
endinterface

// File: rtl/tap_delay_line.sv
// Tapped delay line: DEPTH data/valid stages that either shift in new data
// or recirculate the last stage, with a combinational tap mux on the output.

// One stage: data + valid register with reset > flush > enable priority.
module tap_delay_line_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d_out,
  output logic             v_out
);
  // Flush only drops the valid flag; data is kept so it can still be inspected.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out <= '0;
      v_out <= 1'b0;
    end else if (flush) begin
      v_out <= 1'b0;
    end else if (en) begin
      d_out <= d_in;
      v_out <= v_in;
    end
  end
endmodule

module tap_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SEL_W = 4
) (
  input logic               clk,
  input logic               reset,
  tap_delay_line_if.slave   bus
);
  logic [DEPTH:1][WIDTH-1:0] dat;
  logic [DEPTH:1]            vld_pipe;
  logic [DEPTH:1][WIDTH-1:0] dat_nxt;
  logic [DEPTH:1]            vld_nxt;

  // Stage 1 takes either fresh input or the tail of the line (recirculate);
  // with DEPTH=1 the tail is stage 1 itself, so it reloads its own contents.
  assign dat_nxt[1] = bus.rotate ? dat[DEPTH]      : bus.d;
  assign vld_nxt[1] = bus.rotate ? vld_pipe[DEPTH] : bus.d_valid;

  genvar k;
  generate
    for (k = 2; k <= DEPTH; k++) begin : g_feed
      assign dat_nxt[k] = dat[k-1];
      assign vld_nxt[k] = vld_pipe[k-1];
    end
    for (k = 1; k <= DEPTH; k++) begin : g_stage
      tap_delay_line_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .flush (bus.flush),
        .d_in  (dat_nxt[k]),
        .v_in  (vld_nxt[k]),
        .d_out (dat[k]),
        .v_out (vld_pipe[k])
      );
    end
  endgenerate

  // Tap mux: sel=0 is a straight pass of the input, 1..DEPTH picks a stage,
  // anything beyond the line reads as zero and flags the bad select.
  always_comb begin
    bus.q       = '0;
    bus.q_valid = 1'b0;
    bus.sel_err = 1'b1;
    if (bus.sel == '0) begin
      bus.q       = bus.d;
      bus.q_valid = bus.d_valid;
      bus.sel_err = 1'b0;
    end
    for (int i = 1; i <= DEPTH; i++) begin
      if (int'(bus.sel) == i) begin
        bus.q       = dat[i];
        bus.q_valid = vld_pipe[i];
        bus.sel_err = 1'b0;
      end
    end
  end

  assign bus.full = &vld_pipe;
endmodule

// File: tb/tb_tap_delay_line.sv
// Scoreboard bench for tap_delay_line (WIDTH=8, DEPTH=4, SEL_W=3): a queue
// model of the stages predicts each cycle's outputs; a negedge monitor checks.
module tb_tap_delay_line;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SEL_W = 3;

  typedef struct { logic [WIDTH-1:0] d; logic v; } stg_t;
  typedef struct {
    logic [WIDTH-1:0] q;
    logic             qv;
    logic             full;
    logic             err;
    int               sel;
    string            tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tap_delay_line_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  tap_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  stg_t  m[$];        // m[0] is stage 1, m[DEPTH-1] is stage DEPTH
  bit    model_known = 0;
  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Expected outputs for the current inputs and model state, queued for the monitor.
  function automatic void predict(input logic [WIDTH-1:0] d, input logic dv,
                                  input int sel, input string tag);
    exp_t e;
    e.sel = sel; e.tag = tag;
    e.q = '0; e.qv = 1'b0; e.err = 1'b0; e.full = 1'b1;
    foreach (m[i]) if (!m[i].v) e.full = 1'b0;
    if (sel == 0) begin
      e.q = d; e.qv = dv;
    end else if (sel <= DEPTH) begin
      e.q = m[sel-1].d; e.qv = m[sel-1].v;
    end else begin
      e.err = 1'b1;
    end
    exp_q.push_back(e);
  endfunction

  // One clock: apply inputs, queue the prediction, take the edge, advance the model.
  task automatic step(input logic rst, input logic en, input logic fl, input logic rot,
                      input logic [WIDTH-1:0] d, input logic dv, input int sel,
                      input string tag);
    stg_t t;
    reset = rst; bus.en = en; bus.flush = fl; bus.rotate = rot;
    bus.d = d; bus.d_valid = dv; bus.sel = SEL_W'(sel);
    if (model_known) predict(d, dv, sel, tag);
    @(posedge clk);
    if (rst) begin
      m = {};
      for (int i = 0; i < DEPTH; i++) m.push_back('{d: '0, v: 1'b0});
      model_known = 1;
    end else if (fl) begin
      foreach (m[i]) m[i].v = 1'b0;
    end else if (en) begin
      if (rot) begin
        t = m.pop_back();
        m.push_front(t);
      end else begin
        void'(m.pop_back());
        m.push_front('{d: d, v: dv});
      end
    end
    #1;
  endtask

  // Monitor: outputs are combinational, so one prediction is due every negedge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.q !== e.q || bus.q_valid !== e.qv || bus.full !== e.full ||
          bus.sel_err !== e.err) begin
        n_err++;
        $display("FAIL %s sel=%0d: got q=%h qv=%b full=%b err=%b, want q=%h qv=%b full=%b err=%b",
                 e.tag, e.sel, bus.q, bus.q_valid, bus.full, bus.sel_err,
                 e.q, e.qv, e.full, e.err);
      end
    end
  end

  initial begin
    reset = 1'b1; bus.en = 0; bus.flush = 0; bus.rotate = 0;
    bus.d = '0; bus.d_valid = 0; bus.sel = '0;
    @(posedge clk); #1;
    step(1, 1, 0, 0, 8'h00, 0, 0, "reset");
    step(1, 0, 0, 0, 8'h00, 0, 1, "reset_hold");

    // Reset state: stages empty, sel=0 passes input through
    for (int s = 1; s <= DEPTH; s++) step(0, 0, 0, 0, 8'h5A, 1, s, "post_reset");
    step(0, 0, 0, 0, 8'h5A, 1, 0, "post_reset_pass");

    // Shift-in 11,22,33,44 watching tap 3
    step(0, 1, 0, 0, 8'h11, 1, 3, "shift");
    step(0, 1, 0, 0, 8'h22, 1, 3, "shift");
    step(0, 1, 0, 0, 8'h33, 1, 3, "shift");
    step(0, 1, 0, 0, 8'h44, 1, 3, "shift");

    // Stall with garbage on d
    step(0, 0, 0, 0, 8'hFF, 1, 3, "stall");
    step(0, 0, 0, 0, 8'hFF, 1, 1, "stall");
    step(0, 0, 0, 0, 8'hFF, 1, 4, "stall");
    step(0, 0, 0, 0, 8'hFF, 1, 3, "stall_end");

    // Rotate once, inspect ends, then complete the loop
    step(0, 1, 0, 1, 8'hEE, 0, 1, "rotate1");
    step(0, 0, 0, 0, 8'hEE, 0, 1, "rot_s1");
    step(0, 0, 0, 0, 8'hEE, 0, 4, "rot_s4");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 8'hEE, 0, 2, "rotate");
    for (int s = 1; s <= DEPTH; s++) step(0, 0, 0, 0, 8'h00, 0, s, "rot_back");

    // Flush together with en: valids clear, data retained
    step(0, 1, 1, 0, 8'h77, 1, 2, "flush");
    for (int s = 1; s <= DEPTH; s++) step(0, 0, 0, 0, 8'h77, 1, s, "post_flush");
    step(0, 0, 0, 0, 8'h3C, 1, 0, "flush_pass");

    // Select bounds
    for (int s = 5; s <= 7; s++) step(0, 0, 0, 0, 8'h99, 1, s, "sel_oob");
    step(0, 0, 0, 0, 8'h99, 1, 4, "sel_max");

    // Reset mid-stream
    step(0, 1, 0, 0, 8'hA1, 1, 1, "pre_rst_shift");
    step(0, 1, 0, 0, 8'hA2, 1, 2, "pre_rst_shift");
    step(1, 1, 0, 0, 8'hAA, 1, 1, "mid_reset");
    for (int s = 1; s <= DEPTH; s++) step(0, 0, 0, 0, 8'hAA, 1, s, "after_mid_reset");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 30),
           WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 7)), "random");
    end

    bus.en = 0; bus.flush = 0; reset = 0;
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d predictions unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
